// File: rtl/bp_common_pkg.sv
// Core interface types shared between the front end and back end: configuration
// selector, front-end queue message encodings and the bp_fe_queue_s payload.
package bp_common_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg     = 2'd0,
    e_bp_unicore_cfg     = 2'd1,
    e_bp_multicore_1_cfg = 2'd2
  } bp_params_e;

  localparam int vaddr_width_gp = 39;
  localparam int instr_width_gp = 32;

  typedef enum logic [1:0] {
    e_instr_fetch      = 2'b00,
    e_itlb_miss        = 2'b01,
    e_instr_page_fault = 2'b10,
    e_icache_miss      = 2'b11
  } bp_fe_msg_type_e;

  typedef struct packed {
    bp_fe_msg_type_e             msg_type;
    logic [vaddr_width_gp-1:0]   pc;
    logic [instr_width_gp-1:0]   instr;
  } bp_fe_queue_s;

  // Every supported configuration shares the same front-end message layout.
  function automatic int bp_fe_queue_width(bp_params_e cfg);
    case (cfg)
      e_bp_unicore_cfg:     return $bits(bp_fe_queue_s);
      e_bp_multicore_1_cfg: return $bits(bp_fe_queue_s);
      default:              return $bits(bp_fe_queue_s);
    endcase
  endfunction

endpackage

// File: rtl/bp_fe_pkg.sv
// Front-end local types.
package bp_fe_pkg;

  typedef enum logic {
    e_run  = 1'b0,
    e_hold = 1'b1
  } bp_fe_queue_sender_state_e;

endpackage

// File: rtl/bp_fe_queue_sender_buffer.sv
// Clearable two-entry 1r1w FIFO. Head data and full/empty flags come straight
// from registers, so nothing on the write side reaches the read side in-cycle.
module bp_fe_queue_sender_buffer #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);

  logic [width_p-1:0] mem_r [2];
  logic               wptr_r;
  logic               rptr_r;
  logic [1:0]         count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (v_i)
        wptr_r <= ~wptr_r;
      if (yumi_i)
        rptr_r <= ~rptr_r;
      count_r <= count_r + 2'(v_i) - 2'(yumi_i);
    end
  end

  // Storage needs no reset; count and pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (v_i && !reset_i && !clear_i)
      mem_r[wptr_r] <= data_i;
  end

  assign data_o  = mem_r[rptr_r];
  assign empty_o = (count_r == 2'd0);
  assign full_o  = (count_r == 2'd2);

endmodule

// File: rtl/bp_fe_queue_sender.sv
// Front-end to back-end issue queue sender with exception hold.
// Optional BP_FE_QUEUE_SENDER_COUNTERS_EN adds saturating sent/stall counters.
//
//   state  | meaning
//   e_run  | accepting fetch messages while buffer has room
//   e_hold | an exception/miss message was accepted; refuse input until redirect
module bp_fe_queue_sender
  import bp_common_pkg::*;
  import bp_fe_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         redirect_v_i,
  input  logic [$bits(bp_fe_queue_s)-1:0] fetch_pkt_i,
  input  logic                         fetch_v_i,
  output logic                         fetch_ready_and_o,
  output logic [$bits(bp_fe_queue_s)-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_ready_and_i,
  output logic                         hold_o
`ifdef BP_FE_QUEUE_SENDER_COUNTERS_EN
  , output logic [31:0]                sent_count_o
  , output logic [31:0]                stall_count_o
`endif
);

  localparam int fe_queue_width_lp = bp_fe_queue_width(bp_params_p);
  localparam int msg_type_width_lp = $bits(bp_fe_msg_type_e);

  bp_fe_queue_sender_state_e state_r;
  bp_fe_msg_type_e           fetch_msg_type;
  logic                      buf_empty;
  logic                      buf_full;
  logic                      fetch_xfer;
  logic                      fe_queue_xfer;

  assign fetch_msg_type = bp_fe_msg_type_e'(
    fetch_pkt_i[$bits(bp_fe_queue_s)-1 -: msg_type_width_lp]);

  assign fetch_ready_and_o = ~buf_full & ~hold_o & ~redirect_v_i;
  assign fe_queue_v_o      = ~buf_empty & ~redirect_v_i;
  assign fetch_xfer        = fetch_v_i & fetch_ready_and_o;
  assign fe_queue_xfer     = fe_queue_v_o & fe_queue_ready_and_i;

  bp_fe_queue_sender_buffer #(
    .width_p (fe_queue_width_lp)
  ) buffer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (redirect_v_i),
    .v_i     (fetch_xfer),
    .data_i  (fetch_pkt_i),
    .yumi_i  (fe_queue_xfer),
    .data_o  (fe_queue_o),
    .empty_o (buf_empty),
    .full_o  (buf_full)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_run;
      hold_o  <= 1'b0;
    end else begin
      case (state_r)
        e_run: begin
          if (fetch_xfer && (fetch_msg_type != e_instr_fetch)) begin
            state_r <= e_hold;
            hold_o  <= 1'b1;
          end
        end
        e_hold: begin
          if (redirect_v_i) begin
            state_r <= e_run;
            hold_o  <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef BP_FE_QUEUE_SENDER_COUNTERS_EN
  logic [31:0] sent_count_r;
  logic [31:0] stall_count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sent_count_r  <= 32'd0;
      stall_count_r <= 32'd0;
    end else begin
      if (fe_queue_xfer && (sent_count_r != 32'hFFFF_FFFF))
        sent_count_r <= sent_count_r + 32'd1;
      if (fe_queue_v_o && !fe_queue_ready_and_i && (stall_count_r != 32'hFFFF_FFFF))
        stall_count_r <= stall_count_r + 32'd1;
    end
  end

  assign sent_count_o  = sent_count_r;
  assign stall_count_o = stall_count_r;
`endif

endmodule

// File: tb/tb_bp_fe_queue_sender.sv
// Scoreboard bench for bp_fe_queue_sender: directed scenarios then random traffic.
module tb_bp_fe_queue_sender;
  import bp_common_pkg::*;

  localparam int w_lp = $bits(bp_fe_queue_s);

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            redirect_v_i;
  logic [w_lp-1:0] fetch_pkt_i;
  logic            fetch_v_i;
  logic            fetch_ready_and_o;
  logic [w_lp-1:0] fe_queue_o;
  logic            fe_queue_v_o;
  logic            fe_queue_ready_and_i;
  logic            hold_o;
`ifdef BP_FE_QUEUE_SENDER_COUNTERS_EN
  logic [31:0]     sent_count_o;
  logic [31:0]     stall_count_o;
`endif

  always #5 clk_i = ~clk_i;

  bp_fe_queue_sender #(.bp_params_p(e_bp_default_cfg)) dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .redirect_v_i         (redirect_v_i),
    .fetch_pkt_i          (fetch_pkt_i),
    .fetch_v_i            (fetch_v_i),
    .fetch_ready_and_o    (fetch_ready_and_o),
    .fe_queue_o           (fe_queue_o),
    .fe_queue_v_o         (fe_queue_v_o),
    .fe_queue_ready_and_i (fe_queue_ready_and_i),
    .hold_o               (hold_o)
`ifdef BP_FE_QUEUE_SENDER_COUNTERS_EN
    , .sent_count_o       (sent_count_o)
    , .stall_count_o      (stall_count_o)
`endif
  );

  int unsigned  n_chk  = 0;
  int unsigned  n_pass = 0;
  bit           started = 1'b0;
  bp_fe_queue_s q [$];
  bit           m_hold = 1'b0;
  logic [31:0]  m_sent = '0;
  logic [31:0]  m_stall = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bp_fe_queue_s mk(input bp_fe_msg_type_e t, input logic [38:0] pc);
    bp_fe_queue_s p;
    p.msg_type = t;
    p.pc       = pc;
    p.instr    = 32'h1300_0000 | 32'(pc[15:0]);
    return p;
  endfunction

  task automatic step(input logic rst, input logic redir, input logic fv,
                      input bp_fe_queue_s pkt, input logic rdy);
    bit exp_v, exp_rdy;
    reset_i              = rst;
    redirect_v_i         = redir;
    fetch_v_i            = fv;
    fetch_pkt_i          = pkt;
    fe_queue_ready_and_i = rdy;
    exp_v   = (q.size() != 0) && !redir;
    exp_rdy = (q.size() < 2) && !m_hold && !redir;
    @(negedge clk_i);
    if (started) begin
      chk("fe_queue_v", 128'(fe_queue_v_o), 128'(exp_v));
      chk("fetch_ready", 128'(fetch_ready_and_o), 128'(exp_rdy));
      chk("hold", 128'(hold_o), 128'(m_hold));
      if (exp_v) chk("head", 128'(fe_queue_o), 128'(q[0]));
`ifdef BP_FE_QUEUE_SENDER_COUNTERS_EN
      chk("sent_count", 128'(sent_count_o), 128'(m_sent));
      chk("stall_count", 128'(stall_count_o), 128'(m_stall));
`endif
    end
    @(posedge clk_i);
    #1;
    if (rst) begin
      q.delete();
      m_hold  = 1'b0;
      m_sent  = '0;
      m_stall = '0;
    end else begin
      if (exp_v && rdy) begin
        void'(q.pop_front());
        if (m_sent != 32'hFFFF_FFFF) m_sent++;
      end
      if (exp_v && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (redir) begin
        q.delete();
        m_hold = 1'b0;
      end else if (fv && exp_rdy) begin
        q.push_back(pkt);
        if (pkt.msg_type != e_instr_fetch) m_hold = 1'b1;
      end
    end
    started = 1'b1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, rdy);
  endtask

  initial begin
    bp_fe_queue_s a, b, c, m, d, r;
    a = mk(e_instr_fetch, 39'h100);
    b = mk(e_instr_fetch, 39'h104);
    c = mk(e_instr_fetch, 39'h108);
    m = mk(e_itlb_miss,   39'h200);
    d = mk(e_instr_fetch, 39'h300);

    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(1, 1'b1);

    // back-to-back, back end always ready
    step(1'b0, 1'b0, 1'b1, a, 1'b1);
    step(1'b0, 1'b0, 1'b1, b, 1'b1);
    step(1'b0, 1'b0, 1'b1, c, 1'b1);
    idle(2, 1'b1);

    // backpressure: fill, refuse a third, then drain
    step(1'b0, 1'b0, 1'b1, a, 1'b0);
    step(1'b0, 1'b0, 1'b1, b, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, c, 1'b0);
    idle(3, 1'b1);

    // exception hold and release by redirect
    step(1'b0, 1'b0, 1'b1, m, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, d, 1'b1);
    step(1'b0, 1'b1, 1'b1, d, 1'b1);
    step(1'b0, 1'b0, 1'b1, d, 1'b1);
    idle(2, 1'b1);

    // flush with two buffered and an input in the same cycle
    step(1'b0, 1'b0, 1'b1, a, 1'b0);
    step(1'b0, 1'b0, 1'b1, b, 1'b0);
    step(1'b0, 1'b1, 1'b1, c, 1'b1);
    idle(2, 1'b1);

    // reset with two buffered in HOLD
    step(1'b0, 1'b0, 1'b1, a, 1'b0);
    step(1'b0, 1'b0, 1'b1, m, 1'b0);
    step(1'b0, 1'b0, 1'b1, d, 1'b0);
    step(1'b1, 1'b0, 1'b1, d, 1'b1);
    idle(2, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = mk(($urandom_range(0, 7) == 0) ? bp_fe_msg_type_e'($urandom_range(1, 3)) : e_instr_fetch,
             39'({$urandom(), $urandom()}));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 1)), r, ($urandom_range(0, 3) != 0));
    end

`ifdef BP_FE_QUEUE_SENDER_COUNTERS_EN
    // counter scenario: 5 transfers and 3 stalls from reset, then saturation
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b1, a, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, b, 1'b1);
    idle(2, 1'b1);
    chk("sent_five", 128'(m_sent), 128'(32'd5));
    chk("sent_five_dut", 128'(sent_count_o), 128'(32'd5));
    chk("stall_three_dut", 128'(stall_count_o), 128'(32'd3));
    force dut.sent_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.sent_count_r;
    m_sent = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, c, 1'b1);
    idle(2, 1'b1);
    chk("sent_saturated", 128'(sent_count_o), 128'(32'hFFFF_FFFF));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bp_fe_queue_sender.md
BP_FE_QUEUE_SENDER -- requirements
Module: bp_fe_queue_sender

Interface
REQ-001 Parameter bp_params_p SHALL default to e_bp_default_cfg; it selects the processor configuration and fixes the width of bp_fe_queue_s.
REQ-002 Port clk_i, input, 1 bit: the single clock.
REQ-003 Port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port redirect_v_i, input, 1 bit: front-end redirect; flushes pending messages.
REQ-005 Port fetch_pkt_i, input, $bits(bp_fe_queue_s): message from the fetch pipeline.
REQ-006 Port fetch_v_i, input, 1 bit: fetch_pkt_i is valid.
REQ-007 Port fetch_ready_and_o, output, 1 bit: sender accepts fetch_pkt_i this cycle.
REQ-008 Port fe_queue_o, output, $bits(bp_fe_queue_s): message to the back-end issue queue.
REQ-009 Port fe_queue_v_o, output, 1 bit: fe_queue_o is valid.
REQ-010 Port fe_queue_ready_and_i, input, 1 bit: back-end accepts fe_queue_o.
REQ-011 Port hold_o, output, 1 bit: sender is in HOLD after an exception or miss message.

Function
REQ-012 Input transfer SHALL occur on fetch_v_i & fetch_ready_and_o; output transfer SHALL occur on fe_queue_v_o & fe_queue_ready_and_i.
REQ-013 Buffer: two entries, strict FIFO order, no reordering or duplication.
REQ-014 fetch_ready_and_o = ~full & ~hold_o & ~redirect_v_i, where full is the registered count == 2; ready SHALL stay low when full even if a dequeue occurs in the same cycle.
REQ-015 Latency: a message accepted in cycle N SHALL appear on fe_queue_o no earlier than N+1; there is no combinational path from fetch_pkt_i to fe_queue_o.
REQ-016 fe_queue_v_o = ~empty & ~redirect_v_i; fe_queue_o SHALL be the head entry and SHALL remain stable while fe_queue_v_o is high and not accepted.
REQ-017 A simultaneous enqueue and dequeue SHALL leave the count unchanged and the pointers advanced by one each; pointers SHALL wrap modulo 2.
REQ-018 State machine: RUN goes to HOLD on an accepted message with msg_type != e_instr_fetch.
REQ-019 State machine: HOLD goes to RUN on redirect_v_i; no other transitions exist.
REQ-020 On redirect_v_i, the buffer SHALL empty at the next edge; any fetch_v_i in that cycle SHALL be dropped, and no output transfer occurs in that cycle.
REQ-021 In HOLD, already-buffered messages SHALL continue to drain to the back-end.

Reset
REQ-022 Reset SHALL be synchronous and active-high, and SHALL take priority over redirect_v_i and all transfers.
REQ-023 Reset values: buffer empty, state RUN, fe_queue_v_o=0, hold_o=0, fetch_ready_and_o=1 (when redirect_v_i=0), counters=0.
REQ-024 Reset asserted mid-transfer SHALL discard all buffered messages; nothing is replayed.

Configuration
REQ-025 Macro BP_FE_QUEUE_SENDER_COUNTERS_EN: when defined, add 32-bit saturating counters, exposed as outputs sent_count_o (output transfers) and stall_count_o (cycles with fe_queue_v_o & ~fe_queue_ready_and_i).
REQ-026 When BP_FE_QUEUE_SENDER_COUNTERS_EN is undefined, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package placement: the enum bp_fe_queue_sender_state_e {e_run, e_hold} belongs in bp_fe_pkg; bp_fe_queue_s and its msg_type encodings are reused from the common core interface.
REQ-028 Sub-module: one sub-module, bp_fe_queue_sender_buffer, a clearable two-entry 1r1w FIFO with registered outputs; the FSM and ready/valid logic live in the top module.

Verification
REQ-029 Scenario, back-to-back: back-end always ready; send fetch msgs A, B, C in cycles 1-3 -> A, B, C appear in cycles 2-4, fe_queue_v_o continuous, count ≤1.
REQ-030 Scenario, backpressure: fe_queue_ready_and_i=0; send A and B -> fetch_ready_and_o=0 from cycle 3, fe_queue_o holds A stable; raise ready at cycle 6 -> A then B, with no loss.
REQ-031 Scenario, exception hold: send an e_itlb_miss message M then fetch message D -> M delivered, hold_o=1 one cycle after M is accepted, D is refused; redirect_v_i -> hold_o=0 next cycle and D is accepted.
REQ-032 Scenario, flush: buffer holds 2 messages; assert redirect_v_i with fetch_v_i=1 -> fe_queue_v_o=0 that cycle, buffer empty next cycle, and the input message is dropped.
REQ-033 Scenario, reset: assert reset_i with 2 messages buffered and state HOLD -> next cycle fe_queue_v_o=0, hold_o=0, state RUN, counters=0.
REQ-034 Scenario, counters (macro defined): 5 transfers plus 3 stall cycles -> sent_count_o=5, stall_count_o=3; a preloaded 0xFFFFFFFF stays saturated.
